// File: rtl/dac_sif_pkg.sv
// dac_sif_pkg: shared state encoding and command-word geometry for the DAC serial-interface master.
package dac_sif_pkg;

    typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, SHIFT, HOLD, GAP} sif_state_t;

    localparam int SIF_WORD_BITS = 24;
    localparam int SIF_ADDR_BITS = 7;
    localparam int SIF_DATA_BITS = 16;

endpackage

// File: rtl/sif_clk_div.sv
// sif_clk_div: SCLK generator, toggling every CLK_DIV enabled cycles from a low start.
module sif_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int W = $clog2(CLK_DIV) + 1;

    logic [W-1:0] cnt;
    logic         wrap;

    // Ticks coincide with the edge that changes sclk, so the caller acts in lockstep.
    assign wrap      = en && (cnt == W'(CLK_DIV - 1));
    assign rise_tick = wrap && !sclk;
    assign fall_tick = wrap && sclk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_sif_master.sv
// dac_sif_master: DAC reset sequencer plus write-only 24-bit MSB-first serial command master.
module dac_sif_master
    import dac_sif_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int RESET_HOLD = 64,
    parameter int CS_GAP     = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [SIF_WORD_BITS-1:0] i_cmd_data,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    output logic                     o_busy,
    output logic                     o_init_done,
    output logic                     DAC_CTRL_SDIO,
    output logic                     DAC_CTRL_SDENN,
    output logic                     DAC_CTRL_SCLK,
    output logic                     DAC_CTRL_RESETN
);

    localparam int CMAX = (RESET_HOLD > CLK_DIV)
                        ? ((RESET_HOLD > CS_GAP) ? RESET_HOLD : CS_GAP)
                        : ((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
    localparam int CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] RH_LAST   = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
    localparam logic [4:0]    BIT_LAST  = 5'(SIF_WORD_BITS);

    sif_state_t               state;
    logic [CW-1:0]            cnt;
    logic [4:0]               bit_cnt;
    logic [SIF_WORD_BITS-2:0] shift_reg;
    logic                     rise_tick;
    logic                     fall_tick;

    sif_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .rstn      (rstn),
        .en        (state == SHIFT),
        .sclk      (DAC_CTRL_SCLK),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // bit_cnt counts bits clocked into the DAC (rises); the MSB is loaded straight into SDIO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= RST_LOW;
            cnt             <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            o_cmd_ready     <= 1'b0;
            o_busy          <= 1'b0;
            o_init_done     <= 1'b0;
            DAC_CTRL_SDIO   <= 1'b0;
            DAC_CTRL_SDENN  <= 1'b1;
            DAC_CTRL_RESETN <= 1'b0;
        end else begin
            case (state)
                RST_LOW: begin
                    cnt <= (cnt == RH_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == RH_LAST) begin
                        state           <= RST_WAIT;
                        DAC_CTRL_RESETN <= 1'b1;
                    end
                end
                RST_WAIT: begin
                    cnt <= (cnt == RH_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == RH_LAST) begin
                        state       <= IDLE;
                        o_cmd_ready <= 1'b1;
                        o_init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        state          <= SHIFT;
                        shift_reg      <= i_cmd_data[SIF_WORD_BITS-2:0];
                        bit_cnt        <= '0;
                        DAC_CTRL_SDIO  <= i_cmd_data[SIF_WORD_BITS-1];
                        DAC_CTRL_SDENN <= 1'b0;
                        o_cmd_ready    <= 1'b0;
                        o_busy         <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise_tick) bit_cnt <= bit_cnt + 1'b1;
                    if (fall_tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            shift_reg     <= shift_reg << 1;
                            DAC_CTRL_SDIO <= shift_reg[SIF_WORD_BITS-2];
                        end
                    end
                end
                HOLD: begin
                    cnt <= (cnt == HOLD_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == HOLD_LAST) begin
                        state          <= GAP;
                        DAC_CTRL_SDENN <= 1'b1;
                        DAC_CTRL_SDIO  <= 1'b0;
                    end
                end
                GAP: begin
                    cnt <= (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == GAP_LAST) begin
                        state       <= IDLE;
                        o_cmd_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: state <= RST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sif_master.sv
// tb_dac_sif_master: directed + randomized checks of dac_sif_master against a pin-level frame monitor.
module tb_dac_sif_master;

    localparam int CLK_DIV    = 2;
    localparam int RESET_HOLD = 8;
    localparam int CS_GAP     = 3;

    typedef struct {
        logic [23:0] word;
        int          nbits;
        int          low;
        int          gap;
        int          tog;
    } frame_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        valid = 1'b0;
    logic        sel = 1'b0;
    logic [23:0] data = '0;

    logic rdy0, busy0, init0, sdio0, sdenn0, sclk0, dres0;
    logic rdy1, busy1, init1, sdio1, sdenn1, sclk1, dres1;
    logic m_ready, m_busy, m_sdio, m_sdenn, m_sclk;

    int total = 0;
    int bad = 0;

    frame_t      frames[$];
    logic [23:0] rx = '0;
    int          nb = 0, lo = 0, hi = 0, gap = 0, tg = 0, tail = 0, last_tail = -1;
    bit          counting = 1'b0;
    logic        p_sdenn = 1'b1, p_sclk = 1'b0;

    always #5 clk = ~clk;

    dac_sif_master #(.CLK_DIV(CLK_DIV), .RESET_HOLD(RESET_HOLD), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rstn(rstn), .i_cmd_data(data), .i_cmd_valid(valid && !sel),
        .o_cmd_ready(rdy0), .o_busy(busy0), .o_init_done(init0),
        .DAC_CTRL_SDIO(sdio0), .DAC_CTRL_SDENN(sdenn0), .DAC_CTRL_SCLK(sclk0), .DAC_CTRL_RESETN(dres0)
    );

    dac_sif_master #(.CLK_DIV(1), .RESET_HOLD(RESET_HOLD), .CS_GAP(CS_GAP)) dut1 (
        .clk(clk), .rstn(rstn), .i_cmd_data(data), .i_cmd_valid(valid && sel),
        .o_cmd_ready(rdy1), .o_busy(busy1), .o_init_done(init1),
        .DAC_CTRL_SDIO(sdio1), .DAC_CTRL_SDENN(sdenn1), .DAC_CTRL_SCLK(sclk1), .DAC_CTRL_RESETN(dres1)
    );

    assign m_ready = sel ? rdy1 : rdy0;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_sdio  = sel ? sdio1 : sdio0;
    assign m_sdenn = sel ? sdenn1 : sdenn0;
    assign m_sclk  = sel ? sclk1 : sclk0;

    // Pin monitor: rebuilds each frame from SDENN/SCLK/SDIO as a DAC would see it.
    always @(negedge clk) begin
        if (m_sdenn && !p_sdenn) begin
            frames.push_back('{rx, nb, lo, gap, tg});
            hi = 0;
            counting = 1'b1;
            tail = 0;
        end
        if (!m_sdenn && p_sdenn) begin
            gap = hi;
            rx = '0;
            nb = 0;
            lo = 0;
            tg = 0;
        end
        if (m_sdenn) hi++;
        else lo++;
        if (!m_sdenn && m_sclk != p_sclk) tg++;
        if (!m_sdenn && m_sclk && !p_sclk) begin
            rx = {rx[22:0], m_sdio};
            nb++;
        end
        if (counting) begin
            if (m_busy) tail++;
            else begin
                counting = 1'b0;
                last_tail = tail;
            end
        end
        p_sdenn = m_sdenn;
        p_sclk = m_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_seq();
        bit quiet = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 1; n <= 2 * RESET_HOLD + 2; n++) begin
            @(negedge clk);
            chk("resetn_pin", dres0, 32'(n >= RESET_HOLD));
            chk("ready_rise", rdy0, 32'(n >= 2 * RESET_HOLD));
            chk("init_done", init0, 32'(n >= 2 * RESET_HOLD));
            quiet &= (sdenn0 === 1'b1 && sclk0 === 1'b0 && busy0 === 1'b0);
        end
        chk("quiet_during_init", quiet, 1);
        chk("div1_ready", rdy1, 1);
    endtask

    task automatic send(input logic [23:0] w, input bit noisy);
        int n = 0;
        data = w;
        valid = 1'b1;
        while (!m_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", m_ready, 1);
        @(negedge clk);
        valid = 1'b0;
        data = 24'($urandom);
        if (noisy) begin
            n = 0;
            while (m_busy && n < 500) begin
                data = 24'($urandom);
                valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            valid = 1'b0;
        end
    endtask

    task automatic get_frame(input logic [23:0] w, input int div, output frame_t f);
        int n = 0;
        f = '{24'h0, 0, 0, 0, 0};
        while (frames.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_seen", 32'(frames.size() > 0), 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            chk("frame_word", f.word, w);
            chk("frame_bits", f.nbits, 24);
            chk("frame_low", f.low, 49 * div);
            chk("frame_sclk_toggles", f.tog, 48);
        end
    endtask

    initial begin
        frame_t      f;
        logic [23:0] w;
        int          r, n;
        logic        ps;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sdenn", sdenn0, 1);
        chk("rst_sclk", sclk0, 0);
        chk("rst_sdio", sdio0, 0);
        chk("rst_resetn", dres0, 0);
        chk("rst_ready", rdy0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_init", init0, 0);
        reset_seq();

        send(24'h251234, 1'b0);
        get_frame(24'h251234, CLK_DIV, f);
        repeat (6) @(negedge clk);
        chk("busy_gap_tail", last_tail, CS_GAP);
        chk("ready_after_frame", rdy0, 1);

        send(24'h010001, 1'b0);
        send(24'h02FFFF, 1'b0);
        get_frame(24'h010001, CLK_DIV, f);
        get_frame(24'h02FFFF, CLK_DIV, f);
        chk("b2b_sdenn_high", f.gap, CS_GAP + 1);

        for (int i = 0; i < 4; i++) begin
            w = {1'b0, 23'($urandom)};
            send(w, 1'b1);
            get_frame(w, CLK_DIV, f);
            repeat (10) @(negedge clk);
            chk("no_extra_frame", frames.size(), 0);
            chk("idle_not_busy", busy0, 0);
        end

        send(24'h5A5A5A, 1'b0);
        r = 0;
        n = 0;
        ps = 1'b0;
        while (r < 10 && n < 500) begin
            @(negedge clk);
            #1;
            if (sclk0 && !ps) r++;
            ps = sclk0;
            n++;
        end
        chk("rise10_reached", r, 10);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_sdenn", sdenn0, 1);
        chk("midrst_sclk", sclk0, 0);
        chk("midrst_resetn", dres0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_ready", rdy0, 0);
        chk("midrst_init", init0, 0);
        repeat (3) @(negedge clk);
        frames.delete();
        reset_seq();
        send(24'h3C0F55, 1'b0);
        get_frame(24'h3C0F55, CLK_DIV, f);
        repeat (6) @(negedge clk);
        chk("clean_after_reset", frames.size(), 0);

        sel = 1'b1;
        repeat (2) @(negedge clk);
        send(24'hAAAAAA, 1'b0);
        get_frame(24'hAAAAAA, 1, f);
        w = {1'b0, 23'($urandom)};
        send(w, 1'b1);
        get_frame(w, 1, f);
        repeat (6) @(negedge clk);
        chk("div1_gap_tail", last_tail, CS_GAP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
